filter_sp_write_ctrl: RTL and testbench

- Write-side controller for the filter scratchpad. Pops filter words from the upstream filter FIFO and writes them into the scratchpad as a circular buffer.
- Keeps a count of complete filters resident in the scratchpad. Frees space when the read-side address generator signals that a filter has been consumed.
- Sits between the filter input FIFO and the filter scratchpad. It runs in parallel with the read address generator, which shares the same filter_size.

---
 rtl/filter_sp_write_ctrl.sv | 87 ++++++++
 tb/tb_filter_sp_write_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sp_write_ctrl.sv
// filter_sp_write_ctrl: pops filter words from the FIFO into a circular scratchpad and counts resident filters
//   clk, rst (async, active-low); filter_size, enable; fifo_empty/fifo_dout/fifo_rd_en;
//   sp_we/sp_waddr/sp_wdata; filter_consumed; filters_avail, filter_valid, busy;
//   err (sticky) only when FILTER_SP_ERR_EN is defined.
module filter_sp_write_ctrl #(
  parameter int SP_SIZE              = 8,
  parameter int DATA_WIDTH           = 16,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int CNT_SIZE             = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic                            enable,
  input  logic                            fifo_empty,
  input  logic [DATA_WIDTH-1:0]           fifo_dout,
  output logic                            fifo_rd_en,
  output logic                            sp_we,
  output logic [SP_SIZE-1:0]              sp_waddr,
  output logic [DATA_WIDTH-1:0]           sp_wdata,
  input  logic                            filter_consumed,
  output logic [CNT_SIZE-1:0]             filters_avail,
  output logic                            filter_valid,
  output logic                            busy
`ifdef FILTER_SP_ERR_EN
  ,
  output logic                            err
`endif
);
  localparam int AW = SP_SIZE + 1;
  localparam int UW = SP_SIZE + CNT_SIZE + FILTER_SIZE_REG_SIZE + 2;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] issued, wcnt;
  logic [SP_SIZE-1:0] wr_ptr;
  logic [UW-1:0] fs, used, depth;
  logic can_start, last_wr, dec;
  assign fs           = UW'(filter_size);
  assign depth        = UW'(1) << SP_SIZE;
  // Occupancy is counted in whole filters plus the words of the filter being written.
  assign used         = UW'(filters_avail) * fs + UW'(wcnt);
  assign can_start    = enable && fs != '0 && filters_avail != '1 && used + fs <= depth;
  assign fifo_rd_en   = state == LOAD && !fifo_empty && UW'(issued) < fs;
  assign last_wr      = sp_we && UW'(wcnt) + UW'(1) == fs;
  assign filter_valid = filters_avail != '0;
  assign dec          = filter_consumed && filter_valid;
  assign busy         = state != IDLE;
  assign sp_waddr     = wr_ptr;
  assign sp_wdata     = fifo_dout;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (can_start ? LOAD : IDLE) :
               state == LOAD ? (last_wr ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      issued        <= '0;
      wcnt          <= '0;
      wr_ptr        <= '0;
      sp_we         <= 1'b0;
      filters_avail <= '0;
    end else begin
      state         <= state_nx;
      sp_we         <= fifo_rd_en;
      // Word counters stay live through DONE so occupancy never double-counts the finished filter.
      issued        <= state == LOAD ? issued + AW'(fifo_rd_en) : '0;
      wcnt          <= state == LOAD ? wcnt + AW'(sp_we) : '0;
      wr_ptr        <= wr_ptr + SP_SIZE'(sp_we);
      filters_avail <= filters_avail + CNT_SIZE'(state == DONE) - CNT_SIZE'(dec);
    end
  end
`ifdef FILTER_SP_ERR_EN
  logic [FILTER_SIZE_REG_SIZE-1:0] fs_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err  <= 1'b0;
      fs_q <= '0;
    end else begin
      fs_q <= filter_size;
      if ((filter_consumed && !filter_valid) || (enable && filter_size == '0) ||
          (busy && filter_size != fs_q))
        err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_filter_sp_write_ctrl.sv
// tb_filter_sp_write_ctrl: directed bench for filter_sp_write_ctrl with a 16-word scratchpad
module tb_filter_sp_write_ctrl;
  localparam int SP = 4, DW = 16, FW = 8, CW = 4;
  logic clk = 0, rst = 0, enable = 0, filter_consumed = 0, gate = 0;
  logic [FW-1:0] filter_size = 0;
  logic [DW-1:0] fifo_dout = 0, sp_wdata;
  logic fifo_empty, fifo_rd_en, sp_we, filter_valid, busy;
  logic [SP-1:0] sp_waddr;
  logic [CW-1:0] filters_avail;
`ifdef FILTER_SP_ERR_EN
  logic err;
`endif
  int checks = 0, failures = 0, n_pops = 0, viol = 0, cnt = 0, rd_idx = 0;
  logic prev_rd = 0;
  logic [SP-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [DW-1:0] mem[64];
  filter_sp_write_ctrl #(.SP_SIZE(SP), .DATA_WIDTH(DW), .FILTER_SIZE_REG_SIZE(FW), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst(rst), .filter_size(filter_size), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .sp_we(sp_we), .sp_waddr(sp_waddr), .sp_wdata(sp_wdata),
    .filter_consumed(filter_consumed), .filters_avail(filters_avail),
    .filter_valid(filter_valid), .busy(busy)
`ifdef FILTER_SP_ERR_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  assign fifo_empty = gate || rd_idx >= cnt;
  always @(posedge clk)
    if (!rst) rd_idx <= 0;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  always begin
    @(negedge clk);
    #4;
    if (!rst) prev_rd = 0;
    else begin
      if (fifo_rd_en) n_pops++;
      if (fifo_rd_en && fifo_empty) viol++;
      if (sp_we !== prev_rd) viol++;
      if (sp_we) begin
        wa.push_back(sp_waddr);
        wd.push_back(sp_wdata);
      end
      prev_rd = fifo_rd_en;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) mem[cnt + i] = base + DW'(i);
    cnt += n;
  endtask
  task automatic do_reset();
    rst = 0; enable = 0; filter_consumed = 0; gate = 0; cnt = 0;
    tick(2);
    wa.delete(); wd.delete(); n_pops = 0; viol = 0;
    rst = 1;
    tick(1);
  endtask
  task automatic wait_avail(input int n, input string nm);
    int k = 0;
    while (filters_avail != CW'(n) && k < 300) begin tick(1); k++; end
    checks++;
    if (filters_avail !== CW'(n)) begin
      failures++;
      $display("FAIL %s: filters_avail=%0d, required %0d", nm, filters_avail, n);
    end
  endtask
  task automatic wait_writes(input int n);
    int k = 0, g = 0;
    while (k < n && g < 100) begin tick(1); g++; if (sp_we) k++; end
  endtask
  task automatic check_log(input int n, input logic [SP-1:0] a0, input logic [DW-1:0] d0, input string nm);
    int bad = 0;
    checks++;
    if (wa.size() != n) bad = 100;
    else for (int i = 0; i < n; i++) if (wa[i] !== a0 + SP'(i) || wd[i] !== d0 + DW'(i)) bad++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: writes=%0d bad_entries=%0d, required %0d writes from addr %0d data %h", nm, wa.size(), bad, n, a0, d0);
    end
  endtask
  task automatic test_reset();
    filter_size = 4;
    do_reset();
    checks++;
    if ({sp_we, fifo_rd_en, busy, filter_valid, filters_avail, sp_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_state: we=%b rd=%b busy=%b valid=%b avail=%0d addr=%0d, required all 0",
               sp_we, fifo_rd_en, busy, filter_valid, filters_avail, sp_waddr);
    end
`ifdef FILTER_SP_ERR_EN
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: err=%b, required 0", err); end
`endif
    fill(8, 16'h5000);
    enable = 1;
    wait_writes(2);
    checks++;
    if (sp_waddr !== 4'd1) begin failures++; $display("FAIL midload_addr: sp_waddr=%0d, required 1", sp_waddr); end
    rst = 0;
    #1;
    checks++;
    if ({sp_we, fifo_rd_en, busy, filters_avail, sp_waddr} !== '0) begin
      failures++;
      $display("FAIL midload_reset: we=%b rd=%b busy=%b avail=%0d addr=%0d, required all 0",
               sp_we, fifo_rd_en, busy, filters_avail, sp_waddr);
    end
    enable = 0;
    tick(2);
    rst = 1;
    tick(3);
    checks++;
    if (busy !== 1'b0 || filters_avail !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b avail=%0d, required 0 0", busy, filters_avail);
    end
  endtask
  task automatic test_basic();
    do_reset();
    filter_size = 5;
    fill(10, 16'hA000);
    enable = 1;
    wait_avail(1, "basic_first");
    checks++;
    if (wa.size() != 5) begin failures++; $display("FAIL basic_first_writes: %0d, required 5", wa.size()); end
    wait_avail(2, "basic_second");
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: busy=%b, required 0", busy); end
    check_log(10, 4'd0, 16'hA000, "basic_log");
    checks++;
    if (viol != 0) begin failures++; $display("FAIL basic_latency: violations=%0d, required 0", viol); end
  endtask
  task automatic test_full_stall();
    int p0;
    fill(5, 16'hB000);
    wait_avail(3, "stall_third");
    wa.delete(); wd.delete();
    fill(5, 16'hC000);
    p0 = n_pops;
    tick(8);
    checks++;
    if (n_pops != p0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: pops=%0d busy=%b rd=%b, required 0 0 0", n_pops - p0, busy, fifo_rd_en);
    end
    filter_consumed = 1;
    tick(1);
    filter_consumed = 0;
    checks++;
    if (filters_avail !== 4'd2) begin failures++; $display("FAIL stall_consume: avail=%0d, required 2", filters_avail); end
    wait_avail(3, "stall_reload");
    check_log(5, 4'd15, 16'hC000, "stall_wrap_log");
    checks++;
    if (viol != 0) begin failures++; $display("FAIL stall_latency: violations=%0d, required 0", viol); end
  endtask
  task automatic test_bubbles();
    int k = 0;
    do_reset();
    filter_size = 4;
    fill(4, 16'hD000);
    enable = 1;
    while (filters_avail == '0 && k < 200) begin gate = ~gate; tick(1); k++; end
    gate = 0;
    enable = 0;
    check_log(4, 4'd0, 16'hD000, "bubble_log");
    checks++;
    if (n_pops != 4 || viol != 0) begin
      failures++;
      $display("FAIL bubble_pops: pops=%0d violations=%0d, required 4 0", n_pops, viol);
    end
  endtask
  task automatic test_simul();
    do_reset();
    filter_size = 2;
    fill(4, 16'h1000);
    enable = 1;
    wait_avail(2, "simul_preload");
    fill(2, 16'h2000);
    wait_writes(2);
    tick(1);
    checks++;
    if (busy !== 1'b1 || sp_we !== 1'b0) begin
      failures++;
      $display("FAIL simul_done_cycle: busy=%b we=%b, required 1 0", busy, sp_we);
    end
    filter_consumed = 1;
    tick(1);
    filter_consumed = 0;
    checks++;
    if (filters_avail !== 4'd2) begin failures++; $display("FAIL simul_net_zero: avail=%0d, required 2", filters_avail); end
    tick(5);
    checks++;
    if (filters_avail !== 4'd2) begin failures++; $display("FAIL simul_hold: avail=%0d, required 2", filters_avail); end
`ifdef FILTER_SP_ERR_EN
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL simul_err: err=%b, required 0", err); end
`endif
  endtask
  task automatic test_enable_drop();
    do_reset();
    filter_size = 4;
    fill(8, 16'h3000);
    enable = 1;
    wait_writes(2);
    enable = 0;
    wait_avail(1, "drop_finish");
    tick(10);
    checks++;
    if (filters_avail !== 4'd1 || n_pops != 4 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL drop_stop: avail=%0d pops=%0d busy=%b rd=%b, required 1 4 0 0", filters_avail, n_pops, busy, fifo_rd_en);
    end
    check_log(4, 4'd0, 16'h3000, "drop_log");
  endtask
  task automatic test_zero_consume();
    do_reset();
    filter_consumed = 1;
    tick(1);
    filter_consumed = 0;
    tick(1);
    checks++;
    if (filters_avail !== '0 || filter_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_consume: avail=%0d valid=%b, required 0 0", filters_avail, filter_valid);
    end
`ifdef FILTER_SP_ERR_EN
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL zero_consume_err: err=%b, required 1", err); end
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full_stall();
    test_bubbles();
    test_simul();
    test_enable_drop();
    test_zero_consume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
